// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_ctrl shared types: size codes, FSM states, lane helpers.
// MEM_CTRL_RMW_EN adds the MERGE state for read-modify-write stores.
package mem_access_ctrl_pkg;

  localparam logic [1:0] SZ_WORD = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_BYTE = 2'd2;

`ifdef MEM_CTRL_RMW_EN
  typedef enum logic [2:0] {
    IDLE, RD, LD_DATA, WR, MERGE
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, RD, LD_DATA, WR
  } state_t;
`endif

  // Big-endian lanes: mask[3] is byte offset 0 (bits 31:24)
  function automatic logic [3:0] laneMask(
    input logic [1:0] size,
    input logic [1:0] off
  );
    case (size)
      SZ_WORD: laneMask = 4'b1111;
      SZ_HALF: laneMask = off[1] ? 4'b0011 : 4'b1100;
      SZ_BYTE: laneMask = 4'b1000 >> off;
      default: laneMask = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] replicate(
    input logic [1:0]  size,
    input logic [31:0] data
  );
    case (size)
      SZ_HALF: replicate = {2{data[15:0]}};
      SZ_BYTE: replicate = {4{data[7:0]}};
      default: replicate = data;
    endcase
  endfunction

  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] off
  );
    case (size)
      SZ_WORD: misaligned = (off != 2'd0);
      SZ_HALF: misaligned = off[0];
      SZ_BYTE: misaligned = 1'b0;
      default: misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_merge.sv
// mem_store_merge: replaces the addressed store lanes in a word.
// Also reports the lane mask for byte-enable driven writes.
module mem_store_merge
  import mem_access_ctrl_pkg::*;
(
  input  logic [31:0] oldWord,
  input  logic [31:0] storeData,
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  output logic [31:0] merged,
  output logic [3:0]  mask
);

  logic [31:0] bitMask;
  logic [31:0] repData;

  assign mask    = laneMask(size, offset);
  assign repData = replicate(size, storeData);
  assign bitMask = {{8{mask[3]}}, {8{mask[2]}},
                    {8{mask[1]}}, {8{mask[0]}}};
  assign merged  = (oldWord & ~bitMask) | (repData & bitMask);

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences MEM-stage loads/stores onto a sync RAM.
// Define MEM_CTRL_RMW_EN for read-modify-write sub-word stores.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_zext,
  output logic              stall,
  output logic              done,
  output logic              addr_err,
  output logic [31:0]       rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_t state, nextState;

  logic              accept;
  logic              badReq;
  logic [ADDR_W-1:0] capAddr;
  logic [1:0]        capOff;
  logic [1:0]        capSize;
  logic              capZext;
  logic              capWrite;
  logic [31:0]       capWdata;
  logic [31:0]       oldWord;
  logic [31:0]       mergedWord;
  logic [3:0]        laneEn;
  logic [15:0]       lane16;
  logic [7:0]        lane8;
  logic [31:0]       loadVal;
  logic              memEn;
  logic              memWe;
  logic [3:0]        memBe;
  logic [31:0]       memWdata;
  logic              unusedAddr;

  assign accept = (state == IDLE) && req_valid && !done;
  assign badReq = misaligned(req_size, req_addr[1:0]);
  assign stall  = req_valid && !done;

  assign unusedAddr = ^req_addr[31:ADDR_W+2];

`ifdef MEM_CTRL_RMW_EN
  logic unusedMask;
  assign oldWord    = mem_rdata;
  assign unusedMask = ^laneEn;
`else
  assign oldWord = replicate(capSize, capWdata);
`endif

  mem_store_merge u_merge (
    .oldWord   (oldWord),
    .storeData (capWdata),
    .size      (capSize),
    .offset    (capOff),
    .merged    (mergedWord),
    .mask      (laneEn)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // Next state and memory strobes
  always_comb begin
    nextState = state;
    memEn     = 1'b0;
    memWe     = 1'b0;
    memBe     = 4'b1111;
    memWdata  = capWdata;
    case (state)
      IDLE: begin
        if (accept && !badReq) begin
          if (!req_write)
            nextState = RD;
          else if (req_size == SZ_WORD)
            nextState = WR;
          else
`ifdef MEM_CTRL_RMW_EN
            nextState = RD;
`else
            nextState = WR;
`endif
        end
      end
      RD: begin
        memEn = 1'b1;
`ifdef MEM_CTRL_RMW_EN
        nextState = capWrite ? MERGE : LD_DATA;
`else
        nextState = capWrite ? IDLE : LD_DATA;
`endif
      end
      LD_DATA: nextState = IDLE;
      WR: begin
        memEn = 1'b1;
        memWe = 1'b1;
`ifndef MEM_CTRL_RMW_EN
        memBe    = laneEn;
        memWdata = mergedWord;
`endif
        nextState = IDLE;
      end
`ifdef MEM_CTRL_RMW_EN
      MERGE: begin
        memEn     = 1'b1;
        memWe     = 1'b1;
        memWdata  = mergedWord;
        nextState = IDLE;
      end
`endif
      default: nextState = IDLE;
    endcase
  end

  // Reset gates the strobe so an abandoned write never lands
  assign mem_en    = memEn && !rst;
  assign mem_we    = memWe && !rst;
  assign mem_be    = memBe;
  assign mem_addr  = capAddr;
  assign mem_wdata = memWdata;

  // Big-endian lane extraction and sign/zero extension
  always_comb begin
    lane16  = capOff[1] ? mem_rdata[15:0] : mem_rdata[31:16];
    lane8   = mem_rdata[31:24];
    loadVal = mem_rdata;
    case (capOff)
      2'd1:    lane8 = mem_rdata[23:16];
      2'd2:    lane8 = mem_rdata[15:8];
      2'd3:    lane8 = mem_rdata[7:0];
      default: lane8 = mem_rdata[31:24];
    endcase
    if (capSize == SZ_HALF)
      loadVal = {{16{!capZext && lane16[15]}}, lane16};
    else if (capSize == SZ_BYTE)
      loadVal = {{24{!capZext && lane8[7]}}, lane8};
  end

  // Request capture, completion pulse and load result
  always_ff @(posedge clk) begin
    if (rst) begin
      done     <= 1'b0;
      addr_err <= 1'b0;
      rdata    <= '0;
      capAddr  <= '0;
      capOff   <= '0;
      capSize  <= '0;
      capZext  <= 1'b0;
      capWrite <= 1'b0;
      capWdata <= '0;
    end else begin
      done     <= 1'b0;
      addr_err <= 1'b0;
      if (accept) begin
        capAddr  <= req_addr[ADDR_W+1:2];
        capOff   <= req_addr[1:0];
        capSize  <= req_size;
        capZext  <= req_zext;
        capWrite <= req_write;
        capWdata <= req_wdata;
        if (badReq) begin
          done     <= 1'b1;
          addr_err <= 1'b1;
        end
      end
      case (state)
        LD_DATA: begin
          rdata <= loadVal;
          done  <= 1'b1;
        end
        WR: done <= 1'b1;
`ifdef MEM_CTRL_RMW_EN
        MERGE: done <= 1'b1;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequences CPU load/store requests onto a single-ported synchronous data memory. Handles big-endian byte/half/word sizing, sign/zero extension of loads, and alignment checking. Implements sub-word stores by read-modify-write, or by byte enables when RMW is compiled out. Sits between the MEM pipeline stage and the data RAM, and drives the stage's stall.

## Interface
- ADDR_W, 10, word-address width of data memory (depth 2^ADDR_W words)
- clk  in  1  clock
- rst  in  1  reset; synchronous and active-high
- req_valid  in  1  level request from MEM stage; held until done
- req_write  in  1  1 store, 0 load
- req_addr  in  32  byte address
- req_wdata  in  32  store data; the low byte/half is used for SB/SH
- req_size  in  2  0 word, 1 half, 2 byte, 3 illegal
- req_zext  in  1  load extension: 0 sign, 1 zero
- stall  out  1  combinational: req_valid && !done
- done  out  1  registered one-cycle completion pulse
- addr_err  out  1  registered; valid with done; misaligned or illegal size
- rdata  out  32  registered load result; valid with done, held until next load completes
- mem_en  out  1  memory access strobe
- mem_we  out  1  write enable, qualified by mem_en
- mem_be  out  4  byte enables; [3] = bits 31:24 (byte offset 0)
- mem_addr  out  ADDR_W  word address = req_addr[ADDR_W+1:2] (captured)
- mem_wdata  out  32  write data
- mem_rdata  in  32  read data, valid the cycle after a read strobe

## Operation
- States: IDLE, RD, LD_DATA, WR, MERGE.
- Accept: state IDLE && req_valid && !done. Capture addr, size, zext, write, and wdata into registers.
- Byte lanes are big-endian. Offset = addr[1:0]; offset 0 = bits 31:24, offset 3 = bits 7:0. Half at offset 0 = bits 31:16, offset 2 = bits 15:0.
- Alignment check at accept:
  - Word requires offset 0; half requires offset[0]=0; size 3 is always illegal.
  - On failure: go directly to IDLE with done=1 and addr_err=1. No mem_en. rdata unchanged. No memory side effect.
- Load: IDLE→RD (mem_en=1, mem_we=0)→LD_DATA. In LD_DATA, extract the lane from mem_rdata and extend to 32 bits per zext, then register it into rdata → IDLE with done.
- Word store: IDLE→WR (mem_en=1, mem_we=1, mem_be=1111, mem_wdata=wdata)→IDLE with done.
- Sub-word store (RMW): IDLE→RD→MERGE. In MERGE, mem_wdata = mem_rdata with the addressed lane(s) replaced, driven combinationally; mem_en=1, mem_we=1, mem_be=1111 → IDLE with done.
- mem_en=0 in IDLE and whenever rst=1.
- addr_err=0 on every non-error completion.
- Reset values: state IDLE, done 0, addr_err 0, rdata 0, all captured request registers 0.
- Reset mid-operation: the in-flight access is abandoned. A reset during MERGE or WR must produce no write, because mem_en is gated. No done is issued.

## Timing
- Accept edge = E0.
- Misaligned/illegal: done high in the cycle after E0.
- Word store: write occurs at E1; done high after E1.
- Load: read strobe in cycle E0–E1, data in cycle E1–E2; done and rdata valid after E2.
- Sub-word store (RMW): read at E1, write at E2; done after E2.
- Back-to-back: the next request is accepted the cycle after done (done blocks re-accept). Throughput is therefore one word store per 2 cycles.
- stall is combinational with no registered delay. stall is low exactly in done cycles.

## Configuration
- MEM_CTRL_RMW_EN defined: sub-word stores use the RD→MERGE read-modify-write sequence; mem_be is always 1111.
- MEM_CTRL_RMW_EN undefined: sub-word stores use the word-store path (IDLE→WR).
  - mem_wdata is the store byte/half replicated to all lanes.
  - mem_be selects the lanes: SB offset k → bit 3−k; SH offset 0 → 1100, offset 2 → 0011.
  - MERGE state is absent.
  - Loads are unchanged.

## Structure
- Shared package holds:
  - size encoding constants SZ_WORD=0, SZ_HALF=1, SZ_BYTE=2;
  - state enum;
  - the lane-mask function (size, offset → 4-bit mask).
- Sub-module: mem_store_merge (combinational). Inputs: old word, store data, size, offset. Outputs: merged word and byte-enable mask. Shared by both configurations.
- Load extraction stays inline.

## Test plan
- LW at 0x10, mem[4]=0x11223344 → rdata 0x11223344, done 3 edges after accept, addr_err 0.
- mem word 0x80FF7F80: LB 0x13 zext=0 → 0xFFFFFF80; LBU 0x11 → 0x000000FF; LH 0x12 zext=0 → 0x00007F80; LHU 0x10 → 0x000080FF.
- SB 0xAB to 0x13 over 0x11223344 → mem 0x112233AB.
  - With RMW: read at E1, write at E2.
  - Without RMW: single write, mem_be 0001.
- LH at 0x11, SW at 0x02, and size 3 each → done after 1 edge, addr_err 1, mem_en never high, rdata unchanged.
- SW 0xDEADBEEF to 0x20, then LW 0x20 accepted the cycle after done → rdata 0xDEADBEEF; stall low only in done cycles.
- SH to 0x22 with rst pulsed in the MERGE cycle → no write, mem unchanged, state IDLE, done/addr_err/rdata 0.
